game_speed_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 18 +
 rtl/tick_prescaler.sv | 39 +++
 rtl/game_speed_ctrl.sv | 144 ++++++++++++++
 tb/tb_game_speed_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game pacing controller and its neighbours.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_e;

    localparam logic [1:0] LEVEL_MAX = 2'd3;

    // Divider rate select: level 0 is the slowest (ratio 8), level 3 the fastest (ratio 1).
    function automatic logic [1:0] level_to_rate(input logic [1:0] lvl);
        return ~lvl;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler with terminal compare; tick is the raw terminal-count strobe.
module tick_prescaler #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Left combinational so the owner registers tick and the step count on the same edge.
    assign tick = en && (cnt_q == limit - CNT_W'(1));

    // Clear wins over counting, but does not suppress a terminal tick in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_speed_ctrl.sv
// Game pacing controller: run/pause/over sequencing, speed level, divider select and step tick.
module game_speed_ctrl
    import game_pkg::*;
#(
    parameter int unsigned BASE_DIV = 1250_0000,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned STEP_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    input  logic              level_up,
    input  logic              game_over,
    output logic [1:0]        clk_rate,
    output logic              tick,
    output logic [1:0]        level,
    output logic [1:0]        state,
    output logic [STEP_W-1:0] steps
);

    state_e            state_q, state_d;
    logic [1:0]        level_q, level_d;
    logic [1:0]        rate_q;
    logic              tick_q;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              restart, cnt_en, cnt_clr, lvl_inc;
    logic              term;
    logic [CNT_W-1:0]  limit;

    // rate_q is ~level delayed by one cycle, so the shift amount is 3 - level.
    assign limit = CNT_W'(BASE_DIV) << rate_q;

    tick_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .limit (limit),
        .tick  (term)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; priority game_over > start > pause.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (game_over)  state_d = ST_OVER;
                else if (start) state_d = ST_RUN;
                else if (pause) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (game_over)  state_d = ST_OVER;
                else if (start) state_d = ST_RUN;
                else if (pause) state_d = ST_RUN;
            end
            ST_OVER: begin
                if (start) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control decode: only the highest-priority input legal in this state takes effect.
    always_comb begin
        restart = 1'b0;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        lvl_inc = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                restart = start;
            end
            ST_RUN: begin
                if (game_over) begin
                    restart = 1'b0;
                end else if (start) begin
                    restart = 1'b1;
                end else if (!pause) begin
                    // Saturated level_up falls through to plain counting.
                    cnt_en = 1'b1;
                    if (level_up && (level_q != LEVEL_MAX)) begin
                        lvl_inc = 1'b1;
                        cnt_clr = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                restart = !game_over && start;
            end
            default: restart = 1'b0;
        endcase
        if (restart) cnt_clr = 1'b1;
    end

    // Level and step counter next values.
    always_comb begin
        level_d = level_q;
        steps_d = steps_q;
        if (restart) begin
            level_d = '0;
            steps_d = '0;
        end else begin
            if (lvl_inc) level_d = level_q + 2'd1;
            if (term)    steps_d = steps_q + STEP_W'(1);
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            rate_q  <= 2'b11;
            tick_q  <= 1'b0;
            steps_q <= '0;
        end else begin
            level_q <= level_d;
            rate_q  <= level_to_rate(level_q);
            tick_q  <= term;
            steps_q <= steps_d;
        end
    end

    assign clk_rate = rate_q;
    assign tick     = tick_q;
    assign level    = level_q;
    assign state    = state_q;
    assign steps    = steps_q;

endmodule

// File: tb/tb_game_speed_ctrl.sv
// Self-checking bench for game_speed_ctrl with BASE_DIV = 4 (tick periods 32/16/8/4).
module tb_game_speed_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, pause = 1'b0, level_up = 1'b0, game_over = 1'b0;
    logic [1:0]  clk_rate, level, state;
    logic        tick;
    logic [15:0] steps;

    int unsigned cyc = 0;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;
    int unsigned exp_q[$];
    int unsigned obs_q[$];

    game_speed_ctrl #(
        .BASE_DIV (4),
        .CNT_W    (32),
        .STEP_W   (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pause     (pause),
        .level_up  (level_up),
        .game_over (game_over),
        .clk_rate  (clk_rate),
        .tick      (tick),
        .level     (level),
        .state     (state),
        .steps     (steps)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge number n settles, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    // Record the edge number that raised tick.
    always @(posedge clk) begin
        #1;
        if (tick === 1'b1) obs_q.push_back(cyc);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // v = {game_over, start, pause, level_up}; t returns the edge that sampled the pulse.
    task automatic drive(input logic [3:0] v, output int unsigned t);
        {game_over, start, pause, level_up} = v;
        @(negedge clk);
        {game_over, start, pause, level_up} = 4'b0000;
        t = cyc;
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic test_reset;
        int unsigned t;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (state !== 2'b00 || level !== 2'b00 || clk_rate !== 2'b11 || tick !== 1'b0
            || steps !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_values: got st=%b lv=%b rate=%b tick=%b steps=%0d expected 00 00 11 0 0",
                     state, level, clk_rate, tick, steps);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        drive(4'b1011, t);
        @(negedge clk);
        n_tests++;
        if (state !== 2'b00 || level !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_ignores: got st=%b lv=%b expected 00 00", state, level);
        end
    endtask

    task automatic test_start;
        int unsigned t0, e, o;
        exp_q.delete();
        obs_q.delete();
        drive(4'b0100, t0);
        n_tests++;
        if (state !== 2'b01 || clk_rate !== 2'b11 || steps !== 16'd0) begin
            n_fail++;
            $display("FAIL start_state: got st=%b rate=%b steps=%0d expected 01 11 0",
                     state, clk_rate, steps);
        end
        for (int k = 1; k <= 3; k++) exp_q.push_back(t0 + 32 * k);
        wait_until(t0 + 96);
        n_tests++;
        if (steps !== 16'd3) begin
            n_fail++;
            $display("FAIL start_steps: got %0d expected 3", steps);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = 0;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL start_tick_edge: got %0d expected %0d", o, e);
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL start_extra_ticks: got %0d expected 0", obs_q.size());
        end
    endtask

    task automatic test_level_up;
        int unsigned tl, base, p, e, o, exp_steps;
        logic [1:0] el;
        exp_q.delete();
        obs_q.delete();
        base = 0;
        for (int i = 1; i <= 4; i++) begin
            drive(4'b0001, tl);
            el = (i > 3) ? 2'd3 : 2'(i);
            n_tests++;
            if (level !== el) begin
                n_fail++;
                $display("FAIL level_value: got %0d expected %0d", level, el);
            end
            @(negedge clk);
            n_tests++;
            if (clk_rate !== 2'd3 - el) begin
                n_fail++;
                $display("FAIL level_rate: got %b expected %b", clk_rate, 2'd3 - el);
            end
            p = 32 >> el;
            // A saturated level_up leaves the counter phase untouched.
            if (i <= 3) base = tl;
            for (int k = 1; base + p * k < tl + 100; k++)
                if (base + p * k >= tl) exp_q.push_back(base + p * k);
            wait_until(tl + 99);
        end
        exp_steps = 3 + exp_q.size();
        n_tests++;
        if (steps !== 16'(exp_steps)) begin
            n_fail++;
            $display("FAIL level_steps: got %0d expected %0d", steps, exp_steps);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = 0;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL level_tick_edge: got %0d expected %0d", o, e);
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL level_extra_ticks: got %0d expected 0", obs_q.size());
        end
    endtask

    task automatic test_pause;
        int unsigned ts, tp, tr, e, o;
        drive(4'b0100, ts);
        exp_q.delete();
        obs_q.delete();
        n_tests++;
        if (state !== 2'b01 || level !== 2'b00 || steps !== 16'd0) begin
            n_fail++;
            $display("FAIL restart_run: got st=%b lv=%0d steps=%0d expected 01 0 0",
                     state, level, steps);
        end
        wait_until(ts + 10);
        drive(4'b0010, tp);
        n_tests++;
        if (state !== 2'b10) begin
            n_fail++;
            $display("FAIL pause_state: got %b expected 10", state);
        end
        wait_until(tp + 50);
        n_tests++;
        if (obs_q.size() != 0 || steps !== 16'd0) begin
            n_fail++;
            $display("FAIL pause_no_tick: got ticks=%0d steps=%0d expected 0 0",
                     obs_q.size(), steps);
        end
        drive(4'b0010, tr);
        n_tests++;
        if (state !== 2'b01) begin
            n_fail++;
            $display("FAIL resume_state: got %b expected 01", state);
        end
        exp_q.push_back(tr + 22);
        wait_until(tr + 24);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = 0;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL resume_tick_edge: got %0d expected %0d", o, e);
            end
        end
        n_tests++;
        if (obs_q.size() != 0 || steps !== 16'd1) begin
            n_fail++;
            $display("FAIL resume_steps: got extra=%0d steps=%0d expected 0 1",
                     obs_q.size(), steps);
        end
    endtask

    task automatic test_game_over;
        int unsigned tl, tg, tx, ts, e, o;
        exp_q.delete();
        obs_q.delete();
        drive(4'b0001, tl);
        exp_q.push_back(tl + 16);
        exp_q.push_back(tl + 32);
        // game_over + pause land on the edge where the third tick is due.
        wait_until(tl + 47);
        drive(4'b1010, tg);
        n_tests++;
        if (state !== 2'b11 || tick !== 1'b0 || level !== 2'd1 || steps !== 16'd3) begin
            n_fail++;
            $display("FAIL over_wins: got st=%b tick=%b lv=%0d steps=%0d expected 11 0 1 3",
                     state, tick, level, steps);
        end
        wait_until(tg + 40);
        drive(4'b0011, tx);
        n_tests++;
        if (state !== 2'b11 || level !== 2'd1 || clk_rate !== 2'b10 || steps !== 16'd3) begin
            n_fail++;
            $display("FAIL over_hold: got st=%b lv=%0d rate=%b steps=%0d expected 11 1 10 3",
                     state, level, clk_rate, steps);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = 0;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL over_tick_edge: got %0d expected %0d", o, e);
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL over_extra_ticks: got %0d expected 0", obs_q.size());
        end
        drive(4'b0100, ts);
        n_tests++;
        if (state !== 2'b01 || level !== 2'd0 || steps !== 16'd0) begin
            n_fail++;
            $display("FAIL over_restart: got st=%b lv=%0d steps=%0d expected 01 0 0",
                     state, level, steps);
        end
    endtask

    task automatic test_level_up_on_tick;
        int unsigned ts, tu, e, o;
        drive(4'b0100, ts);
        exp_q.delete();
        obs_q.delete();
        wait_until(ts + 31);
        drive(4'b0001, tu);
        exp_q.push_back(ts + 32);
        exp_q.push_back(ts + 48);
        exp_q.push_back(ts + 64);
        n_tests++;
        if (level !== 2'd1 || tick !== 1'b1) begin
            n_fail++;
            $display("FAIL lvl_on_tick: got lv=%0d tick=%b expected 1 1", level, tick);
        end
        wait_until(ts + 70);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = 0;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL lvl_on_tick_edge: got %0d expected %0d", o, e);
            end
        end
        n_tests++;
        if (obs_q.size() != 0 || steps !== 16'd3) begin
            n_fail++;
            $display("FAIL lvl_on_tick_steps: got extra=%0d steps=%0d expected 0 3",
                     obs_q.size(), steps);
        end
    endtask

    task automatic test_reset_mid_run;
        int unsigned ts, t;
        drive(4'b0100, ts);
        drive(4'b0001, t);
        drive(4'b0001, t);
        wait_until(ts + 26);
        n_tests++;
        if (level !== 2'd2 || steps !== 16'd3 || tick !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got lv=%0d steps=%0d tick=%b expected 2 3 1",
                     level, steps, tick);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (state !== 2'b00 || level !== 2'b00 || clk_rate !== 2'b11 || tick !== 1'b0
            || steps !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: got st=%b lv=%b rate=%b tick=%b steps=%0d expected 00 00 11 0 0",
                     state, level, clk_rate, tick, steps);
        end
        @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete();
        wait_until(cyc + 80);
        n_tests++;
        if (obs_q.size() != 0 || state !== 2'b00 || steps !== 16'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got ticks=%0d st=%b steps=%0d expected 0 00 0",
                     obs_q.size(), state, steps);
        end
        drive(4'b0100, t);
        n_tests++;
        if (state !== 2'b01) begin
            n_fail++;
            $display("FAIL post_reset_start: got %b expected 01", state);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_level_up();
        test_pause();
        test_game_over();
        test_level_up_on_tick();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
